// File: rtl/tree_coupler_fifo.sv
// Width-doubling pairing FIFO between merger-tree levels.
// Optional: COUPLER_COUNT_EN adds o_count and sim-only misuse checks.
module tree_coupler_fifo #(
    parameter int REC_W   = 32,
    parameter int IN_RECS = 4,
    parameter int DEPTH   = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [IN_RECS*REC_W-1:0]       i_data,
    input  logic                           i_enq,
    input  logic                           i_flush,
    input  logic                           i_deq,
    output logic [2*IN_RECS*REC_W-1:0]     o_data,
    output logic                           o_empty,
    output logic                           o_full,
    output logic                           o_half
`ifdef COUPLER_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0]         o_count
`endif
);
    localparam int IW = IN_RECS * REC_W;
    localparam int OW = 2 * IW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        HALF_EMPTY = 1'b0,
        HALF_HELD  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_half;
    logic [OW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_deq_ok;
    logic            w_room;
    logic            w_push;
    logic            w_latch;
    logic [OW-1:0]   w_push_data;

    assign w_deq_ok = i_deq && (r_count != '0);
    // Room check is uniform: a latch is refused at full too, matching upstream ready.
    assign w_room   = (r_count != CW'(DEPTH)) || w_deq_ok;

    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_latch     = 1'b0;
        w_push_data = '0;
        unique case (r_state)
            HALF_EMPTY: begin
                if (i_enq && w_room) begin
                    if (i_flush) begin
                        w_push      = 1'b1;
                        w_push_data = {{IW{1'b0}}, i_data};
                    end else begin
                        w_latch = 1'b1;
                        w_next  = HALF_HELD;
                    end
                end
            end
            HALF_HELD: begin
                if (i_enq && w_room) begin
                    w_push      = 1'b1;
                    w_push_data = {i_data, r_half};
                    w_next      = HALF_EMPTY;
                end else if (i_flush && !i_enq && w_room) begin
                    w_push      = 1'b1;
                    w_push_data = {{IW{1'b0}}, r_half};
                    w_next      = HALF_EMPTY;
                end
            end
            default: w_next = HALF_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= HALF_EMPTY;
            r_half  <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_half <= i_data;
            end
        end
    end

    // Storage is cleared on reset so o_data reads zero while in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_deq_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_deq_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_deq_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_half  = (r_state == HALF_HELD);

`ifdef COUPLER_COUNT_EN
    assign o_count = r_count;

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (i_enq && !w_room) begin
                $error("tree_coupler_fifo: enq ignored while full");
            end
            if (i_deq && (r_count == '0)) begin
                $error("tree_coupler_fifo: deq ignored while empty");
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_tree_coupler_fifo.sv
// Directed bench for tree_coupler_fifo at REC_W=32, IN_RECS=4, DEPTH=4.
module tb_tree_coupler_fifo;
    logic         clk;
    logic         rst_n;
    logic [127:0] data;
    logic         enq;
    logic         flush;
    logic         deq;
    logic [255:0] q;
    logic         empty;
    logic         full;
    logic         half;

    int total;
    int bad;

    tree_coupler_fifo #(
        .REC_W  (32),
        .IN_RECS(4),
        .DEPTH  (4)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_data (data),
        .i_enq  (enq),
        .i_flush(flush),
        .i_deq  (deq),
        .o_data (q),
        .o_empty(empty),
        .o_full (full),
        .o_half (half)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] w(input int k);
        logic [31:0] b;
        b = 32'(4 * k);
        return {b + 32'd4, b + 32'd3, b + 32'd2, b + 32'd1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq   = 1'b0;
        flush = 1'b0;
        deq   = 1'b0;
    endtask

    task automatic put(input logic [127:0] d);
        idle();
        data = d;
        enq  = 1'b1;
        step();
        idle();
    endtask

    task automatic pop();
        idle();
        deq = 1'b1;
        step();
        idle();
    endtask

    logic [127:0] c_w;
    logic [127:0] d_w;
    logic [127:0] e_w;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        data  = '0;
        idle();

        #12;
        chk("rst_empty", 256'(empty), 256'd1);
        chk("rst_full", 256'(full), 256'd0);
        chk("rst_half", 256'(half), 256'd0);
        chk("rst_data", q, 256'd0);
        rst_n = 1'b1;
        step();
        chk("idle_empty", 256'(empty), 256'd1);

        // basic pairing: A low, B high
        put(w(0));
        chk("a_half", 256'(half), 256'd1);
        chk("a_empty", 256'(empty), 256'd1);
        put(w(1));
        chk("b_half", 256'(half), 256'd0);
        chk("b_empty", 256'(empty), 256'd0);
        chk("ba_data", q, {w(1), w(0)});
        pop();
        chk("ba_popped", 256'(empty), 256'd1);

        // fill to full, overflow ignored, drain with pointer wrap
        for (int k = 0; k < 8; k++) begin
            put(w(10 + k));
        end
        chk("fill_full", 256'(full), 256'd1);
        put(w(30));
        chk("ovf_half", 256'(half), 256'd0);
        chk("ovf_full", 256'(full), 256'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), q, {w(11 + 2 * k), w(10 + 2 * k)});
            pop();
        end
        chk("drain_empty", 256'(empty), 256'd1);
        chk("drain_half", 256'(half), 256'd0);

        // at full: latch C with a pop, then push {D,C} with a pop
        for (int k = 0; k < 8; k++) begin
            put(w(40 + k));
        end
        chk("refill_full", 256'(full), 256'd1);
        c_w = w(60);
        d_w = w(61);
        idle();
        data = c_w;
        enq  = 1'b1;
        deq  = 1'b1;
        step();
        chk("c_half", 256'(half), 256'd1);
        chk("c_full", 256'(full), 256'd0);
        chk("c_head", q, {w(43), w(42)});
        data = d_w;
        enq  = 1'b1;
        deq  = 1'b1;
        step();
        idle();
        chk("d_half", 256'(half), 256'd0);
        chk("d_full", 256'(full), 256'd0);
        chk("d_head", q, {w(45), w(44)});
        pop();
        chk("d_next", q, {w(47), w(46)});
        pop();
        chk("dc_tail", q, {d_w, c_w});
        pop();
        chk("dc_empty", 256'(empty), 256'd1);

        // flush of a held half word
        e_w = w(70);
        put(e_w);
        chk("e_half", 256'(half), 256'd1);
        idle();
        flush = 1'b1;
        step();
        idle();
        chk("flush_half", 256'(half), 256'd0);
        chk("flush_empty", 256'(empty), 256'd0);
        chk("flush_data", q, {128'h0, e_w});
        pop();
        chk("flush_pop", 256'(empty), 256'd1);

        // flush alone is a no-op
        flush = 1'b1;
        step();
        idle();
        chk("nop_empty", 256'(empty), 256'd1);
        chk("nop_half", 256'(half), 256'd0);

        // flush with enq in HALF_EMPTY pushes directly
        data  = w(80);
        enq   = 1'b1;
        flush = 1'b1;
        step();
        idle();
        chk("fe_half", 256'(half), 256'd0);
        chk("fe_data", q, {128'h0, w(80)});
        pop();
        chk("fe_pop", 256'(empty), 256'd1);

        // async reset with 3 stored pairs and a held half
        for (int k = 0; k < 7; k++) begin
            put(w(90 + k));
        end
        chk("pre_half", 256'(half), 256'd1);
        chk("pre_empty", 256'(empty), 256'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_empty", 256'(empty), 256'd1);
        chk("ar_half", 256'(half), 256'd0);
        chk("ar_full", 256'(full), 256'd0);
        chk("ar_data", q, 256'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_empty", 256'(empty), 256'd1);
        chk("post_half", 256'(half), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
